// File: rtl/riscv_pkg.sv
// Shared widths, constants and PC helpers for the front end.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0]   PC_INC           = 32'd4;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect and decode handshake.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [XLEN-1:0]   id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_unit_checker.sv
// Runtime invariants of the fetch unit's two FIFOs and in-flight bookkeeping.
module fetch_unit_checker #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          ififo_push,
  input logic          ififo_pop,
  input logic          ififo_full,
  input logic          tfifo_push,
  input logic          tfifo_pop,
  input logic          tfifo_full,
  input logic          tfifo_empty,
  input logic [CW-1:0] tfifo_count,
  input logic [CW-1:0] inflight
);

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(ififo_push && ififo_full && !ififo_pop))
        else $error("instruction FIFO overflow");
      assert (!(tfifo_push && tfifo_full))
        else $error("PC tag FIFO overflow");
      assert (!(tfifo_pop && tfifo_empty))
        else $error("response arrived with no PC tag");
      assert (tfifo_count <= inflight)
        else $error("more PC tags than requests in flight");
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head is read straight from registered storage.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ptr_inc(wr_q);
      end else begin
        wr_d = wr_q;
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end else begin
        rd_d = rd_q;
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC owner, credit-limited imem requests, redirect flush and decode FIFO.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = XLEN + INST_W;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [FW-1:0]   hold_q, hold_d;

  logic            credit, req_fire, rsp_keep, ififo_pop;
  logic            ififo_full, ififo_empty, tfifo_full, tfifo_empty;
  logic [CW-1:0]   ififo_count, tfifo_count;
  logic [FW-1:0]   ififo_head;
  logic [XLEN-1:0] tag_head;

  // Credits come only from registered counts; a same-cycle pop frees one next cycle.
  assign credit   = ({1'b0, inflight_q} + {1'b0, ififo_count}) < (CW+1)'(DEPTH);
  assign bus.imem_req_valid = rst_n && !bus.redirect_valid && credit;
  assign bus.imem_req_addr  = pc_q;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep = bus.imem_rsp_valid && (discard_q == '0) && !bus.redirect_valid;

  assign ififo_pop             = !ififo_empty && bus.id_ready;
  assign bus.id_valid          = !ififo_empty;
  assign {bus.id_pc, bus.id_inst} = ififo_empty ? hold_q : ififo_head;

  always_comb begin
    pc_d       = pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    hold_d     = ififo_empty ? hold_q : ififo_head;
    if (bus.redirect_valid) begin
      pc_d      = align_pc(bus.redirect_pc);
      // inflight already counts stale responses, so everything still outstanding is dropped.
      discard_d = inflight_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + PC_INC;
      end else begin
        pc_d = pc_q;
      end
      if (bus.imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end else begin
        discard_d = discard_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      hold_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      hold_q     <= hold_d;
    end
  end

  sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_ififo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ({tag_head, bus.imem_rsp_data}),
    .pop       (ififo_pop),
    .flush     (bus.redirect_valid),
    .full      (ififo_full),
    .empty     (ififo_empty),
    .count     (ififo_count),
    .head      (ififo_head)
  );

  // Tags are popped only for responses that are kept; stale ones were flushed with the redirect.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tfifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .flush     (bus.redirect_valid),
    .full      (tfifo_full),
    .empty     (tfifo_empty),
    .count     (tfifo_count),
    .head      (tag_head)
  );

  fetch_unit_checker #(.CW(CW)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .ififo_push  (rsp_keep),
    .ififo_pop   (ififo_pop),
    .ififo_full  (ififo_full),
    .tfifo_push  (req_fire),
    .tfifo_pop   (rsp_keep),
    .tfifo_full  (tfifo_full),
    .tfifo_empty (tfifo_empty),
    .tfifo_count (tfifo_count),
    .inflight    (inflight_q)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model plus hand-computed checks.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic clk, rst_n, rst5_n;
  fetch_unit_if bus();
  fetch_unit_if bus5();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut5 (
    .clk(clk), .rst_n(rst5_n), .bus(bus5)
  );

  int vectors     = 0;
  int miscompares = 0;
  int lat         = 1;
  bit use_nop     = 1'b1;
  int mcyc        = 0;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] exp5 [3];
  logic [31:0] exp_addr, exp_pc;
  int nfire, npop, k5, pend5;
  bit got, done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask

  function automatic bit fire();
    return bus.imem_req_valid && bus.imem_req_ready;
  endfunction

  function automatic bit pop();
    return bus.id_valid && bus.id_ready;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return use_nop ? NOP_INST : (a ^ 32'hC0DE_0000);
  endfunction

  // In-order memory: answers each accepted request exactly lat cycles later.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      mcyc++;
      #1;
      if (!rst_n) begin
        mq_addr.delete();
        mq_due.delete();
        bus.imem_rsp_valid = 1'b0;
      end else if (mq_due.size() > 0 && mq_due[0] <= mcyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
      #3;
      if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
        mq_addr.push_back(bus.imem_req_addr);
        mq_due.push_back(mcyc + lat);
      end
    end
  end

  initial begin
    rst_n = 1'b1; rst5_n = 1'b0;
    bus.imem_req_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b1;
    bus5.imem_req_ready = 1'b1; bus5.imem_rsp_valid = 1'b0; bus5.imem_rsp_data = NOP_INST;
    bus5.redirect_valid = 1'b0; bus5.redirect_pc = 32'h0; bus5.id_ready = 1'b1;
    exp5[0] = 32'hFFFF_FFF8; exp5[1] = 32'hFFFF_FFFC; exp5[2] = 32'h0000_0000;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk1("rst_id_valid", bus.id_valid, 1'b0);
    chk32("rst_id_inst", bus.id_inst, 32'h0);
    chk32("rst_id_pc", bus.id_pc, 32'h0);

    // 1: sequential fetch with a 1-cycle NOP memory.
    next_cycle(); rst_n = 1'b1; #1;
    exp_addr = 32'h0; exp_pc = 32'h0;
    for (int c = 0; c < 12; c++) begin
      if (c < 2) chk1("t1_idv_early", bus.id_valid, 1'b0);
      else if (c == 2) chk1("t1_idv_first", bus.id_valid, 1'b1);
      if (fire()) begin
        chk32("t1_addr", bus.imem_req_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (pop()) begin
        chk32("t1_id_pc", bus.id_pc, exp_pc);
        chk32("t1_id_inst", bus.id_inst, 32'h0000_0013);
        exp_pc = exp_pc + 32'd4;
      end
      next_cycle();
    end

    // 2: decode stalled, credits cap requests at DEPTH, then drain in order.
    rst_n = 1'b0; bus.id_ready = 1'b0;
    next_cycle(); rst_n = 1'b1; #1;
    nfire = 0;
    for (int c = 0; c < 10; c++) begin
      if (fire()) nfire++;
      next_cycle();
    end
    chk32("t2_req_count", 32'(nfire), 32'd2);
    chk1("t2_req_idle", bus.imem_req_valid, 1'b0);
    chk1("t2_id_valid", bus.id_valid, 1'b1);
    bus.id_ready = 1'b1; #1;
    npop = 0; got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (pop()) begin
        if (npop == 0) chk32("t2_pop0_pc", bus.id_pc, 32'h0);
        else if (npop == 1) chk32("t2_pop1_pc", bus.id_pc, 32'h4);
        npop++;
      end
      if (fire() && !got) begin
        chk32("t2_next_addr", bus.imem_req_addr, 32'h8);
        got = 1'b1;
      end
      next_cycle();
    end
    chk1("t2_drained", npop >= 2, 1'b1);

    // 3: redirect with two requests outstanding on a 3-cycle memory.
    rst_n = 1'b0; lat = 3; use_nop = 1'b0;
    next_cycle(); rst_n = 1'b1; #1;
    next_cycle(); next_cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_1003; #1;
    chk1("t3_no_req_in_redirect", bus.imem_req_valid, 1'b0);
    next_cycle(); bus.redirect_valid = 1'b0; #1;
    got = 1'b0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (fire() && !got) begin
        chk32("t3_redirect_addr", bus.imem_req_addr, 32'h0000_1000);
        got = 1'b1;
      end
      if (pop()) begin
        chk32("t3_first_pc", bus.id_pc, 32'h0000_1000);
        chk32("t3_first_inst", bus.id_inst, 32'hC0DE_1000);
        done = 1'b1;
      end
      if (!done) next_cycle();
    end
    chk1("t3_completed", done, 1'b1);

    // 4: redirect coinciding with a response.
    next_cycle(); rst_n = 1'b0;
    next_cycle(); rst_n = 1'b1; #1;
    next_cycle(); next_cycle(); next_cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_2002; #1;
    next_cycle(); bus.redirect_valid = 1'b0; #1;
    chk32("t4_discard", 32'(dut.discard_q), 32'd1);
    chk1("t4_word_dropped", bus.id_valid, 1'b0);
    got = 1'b0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (fire() && !got) begin
        chk32("t4_redirect_addr", bus.imem_req_addr, 32'h0000_2000);
        got = 1'b1;
      end
      if (pop()) begin
        chk32("t4_first_pc", bus.id_pc, 32'h0000_2000);
        chk32("t4_first_inst", bus.id_inst, 32'hC0DE_2000);
        done = 1'b1;
      end
      if (!done) next_cycle();
    end
    chk1("t4_completed", done, 1'b1);

    // 6: asynchronous reset mid-stream, then restart at RESET_PC.
    next_cycle(); bus.id_ready = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
    chk1("t6_pre_id_valid", bus.id_valid, 1'b1);
    chk32("t6_pre_id_pc", bus.id_pc, 32'h0000_2004);
    chk32("t6_pre_id_inst", bus.id_inst, 32'hC0DE_2004);
    #1 rst_n = 1'b0;
    #1;
    chk1("t6_req_valid", bus.imem_req_valid, 1'b0);
    chk1("t6_id_valid", bus.id_valid, 1'b0);
    chk32("t6_id_pc", bus.id_pc, 32'h0);
    chk32("t6_id_inst", bus.id_inst, 32'h0);
    chk32("t6_inflight", 32'(dut.inflight_q), 32'd0);
    next_cycle(); rst_n = 1'b1; bus.id_ready = 1'b1; #1;
    chk1("t6_restart_valid", bus.imem_req_valid, 1'b1);
    chk32("t6_restart_addr", bus.imem_req_addr, 32'h0);

    // 5: PC wrap-around from RESET_PC = FFFF_FFF8 on the second instance.
    next_cycle(); rst5_n = 1'b1; #1;
    k5 = 0; pend5 = 0;
    for (int c = 0; c < 16 && k5 < 3; c++) begin
      if (bus5.imem_req_valid && bus5.imem_req_ready) begin
        chk32("t5_addr", bus5.imem_req_addr, exp5[k5]);
        k5++;
        pend5++;
      end
      next_cycle();
      bus5.imem_rsp_valid = (pend5 > 0);
      if (pend5 > 0) pend5--;
      #1;
    end
    chk32("t5_req_count", 32'(k5), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
